// File: rtl/memory_to_uart_sender.sv
// -----------------------------------------------------------------------------
// memory_to_uart_sender
//   Transmit-side sequencer: walks RAM from address 0 to BYTE_COUNT-1 during the
//   router's send phase and hands each byte to the UART TX with a one-cycle
//   start pulse and busy handshake, then flags completion.
//
// Ports
//   MAIN_CLOCK          in   system clock, rising edge
//   RESET               in   asynchronous, active-high reset
//   START_TRANSMISSION  in   level from router; high = send phase
//   RAM_ADDRESS         out  read address to router
//   UART_WRITE_EN       out  RAM write enable to router (always 0)
//   RAM_DATA            in   RAM read data
//   TX_BUSY             in   UART TX shifting a frame
//   TX_START            out  one-cycle pulse: load TX_DATA, start frame
//   TX_DATA             out  byte for the UART TX
//   TRANSMISSION_DONE   out  high once all bytes have left the UART
//   BYTES_SENT          out  completed frames in this transfer
// -----------------------------------------------------------------------------
module memory_to_uart_sender #(
    parameter int unsigned ADDR_WIDTH       = 16,
    parameter int unsigned BYTE_COUNT       = 16384,
    parameter int unsigned RAM_READ_LATENCY = 1
) (
    input  logic                  MAIN_CLOCK,
    input  logic                  RESET,
    input  logic                  START_TRANSMISSION,
    output logic [ADDR_WIDTH-1:0] RAM_ADDRESS,
    output logic                  UART_WRITE_EN,
    input  logic [7:0]            RAM_DATA,
    input  logic                  TX_BUSY,
    output logic                  TX_START,
    output logic [7:0]            TX_DATA,
    output logic                  TRANSMISSION_DONE,
    output logic [ADDR_WIDTH:0]   BYTES_SENT
);

    localparam int unsigned SENT_W = ADDR_WIDTH + 1;
    localparam int unsigned LAT_W  = 3;

    // End-of-transfer compare value; never wraps, all-ones when BYTE_COUNT fills the space
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BYTE_COUNT - 1);
    localparam logic [LAT_W-1:0]      LAT_LAST  = LAT_W'(RAM_READ_LATENCY - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SEND,
        ST_ACK,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [SENT_W-1:0]     sent_q,  sent_d;
    logic [LAT_W-1:0]      lat_q,   lat_d;
    logic [7:0]            data_q,  data_d;
    logic                  start_q, start_d;
    logic                  done_q,  done_d;

    // State and registered outputs
    always_ff @(posedge MAIN_CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            sent_q  <= '0;
            lat_q   <= '0;
            data_q  <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sent_q  <= sent_d;
            lat_q   <= lat_d;
            data_q  <= data_d;
            start_q <= start_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-output logic; TX_START/DONE are decoded from the
    // state being entered so they are registered alongside it.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sent_d  = sent_q;
        lat_d   = lat_q;
        data_d  = data_q;
        start_d = 1'b0;
        done_d  = 1'b0;

        if ((state_q != ST_IDLE) && !START_TRANSMISSION) begin
            // Abort: any frame already in the UART finishes by itself
            state_d = ST_IDLE;
            addr_d  = '0;
            sent_d  = '0;
            lat_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    addr_d = '0;
                    sent_d = '0;
                    lat_d  = '0;
                    if (START_TRANSMISSION) begin
                        state_d = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (lat_q == LAT_LAST) begin
                        lat_d   = '0;
                        state_d = ST_LOAD;
                    end else begin
                        lat_d = lat_q + LAT_W'(1);
                    end
                end
                ST_LOAD: begin
                    // Capture only when the UART is idle so TX_DATA never moves under a frame
                    if (!TX_BUSY) begin
                        data_d  = RAM_DATA;
                        state_d = ST_SEND;
                        start_d = 1'b1;
                    end
                end
                ST_SEND: begin
                    state_d = ST_ACK;
                end
                ST_ACK: begin
                    if (TX_BUSY) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!TX_BUSY) begin
                        sent_d = sent_q + SENT_W'(1);
                        if (addr_q == LAST_ADDR) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            addr_d  = addr_q + ADDR_WIDTH'(1);
                            state_d = ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    done_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign RAM_ADDRESS       = addr_q;
    assign UART_WRITE_EN     = 1'b0;
    assign TX_START          = start_q;
    assign TX_DATA           = data_q;
    assign TRANSMISSION_DONE = done_q;
    assign BYTES_SENT        = sent_q;

endmodule

// File: tb/tb_memory_to_uart_sender.sv
// -----------------------------------------------------------------------------
// tb_memory_to_uart_sender
//   Three sender instances sharing clock and reset:
//     A: ADDR_WIDTH=4, BYTE_COUNT=4,  latency 1, RAM {A5,3C,FF,00}, busy 10
//     B: ADDR_WIDTH=4, BYTE_COUNT=16, latency 3, RAM = addr^5A,     busy 5
//     C: ADDR_WIDTH=4, BYTE_COUNT=1,  latency 1, RAM {A5,..},       busy 4
// -----------------------------------------------------------------------------
module tb_memory_to_uart_sender;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance A ----------------
    logic       start_a = 1'b0;
    logic [3:0] addr_a;
    logic       we_a;
    logic [7:0] rd_a = 8'h00;
    logic       busy_a;
    logic       txs_a;
    logic [7:0] txd_a;
    logic       done_a;
    logic [4:0] sent_a;
    logic       force_busy = 1'b0;
    logic       ub_a = 1'b0;
    int         uc_a = 0;
    logic [7:0] mem_a [0:3] = '{8'hA5, 8'h3C, 8'hFF, 8'h00};

    memory_to_uart_sender #(.ADDR_WIDTH(4), .BYTE_COUNT(4), .RAM_READ_LATENCY(1)) u_a (
        .MAIN_CLOCK(clk), .RESET(rst), .START_TRANSMISSION(start_a),
        .RAM_ADDRESS(addr_a), .UART_WRITE_EN(we_a), .RAM_DATA(rd_a),
        .TX_BUSY(busy_a), .TX_START(txs_a), .TX_DATA(txd_a),
        .TRANSMISSION_DONE(done_a), .BYTES_SENT(sent_a)
    );

    always @(posedge clk) rd_a <= mem_a[addr_a[1:0]];
    always @(posedge clk) begin
        if (txs_a) begin
            ub_a <= 1'b1;
            uc_a <= 10;
        end else if (ub_a) begin
            if (uc_a == 1) ub_a <= 1'b0;
            uc_a <= uc_a - 1;
        end
    end
    assign busy_a = ub_a | force_busy;

    // ---------------- instance B ----------------
    logic       start_b = 1'b0;
    logic [3:0] addr_b;
    logic       we_b;
    logic [7:0] p1_b = 8'h00, p2_b = 8'h00, p3_b = 8'h00;
    logic       busy_b;
    logic       txs_b;
    logic [7:0] txd_b;
    logic       done_b;
    logic [4:0] sent_b;
    logic       ub_b = 1'b0;
    int         uc_b = 0;

    memory_to_uart_sender #(.ADDR_WIDTH(4), .BYTE_COUNT(16), .RAM_READ_LATENCY(3)) u_b (
        .MAIN_CLOCK(clk), .RESET(rst), .START_TRANSMISSION(start_b),
        .RAM_ADDRESS(addr_b), .UART_WRITE_EN(we_b), .RAM_DATA(p3_b),
        .TX_BUSY(busy_b), .TX_START(txs_b), .TX_DATA(txd_b),
        .TRANSMISSION_DONE(done_b), .BYTES_SENT(sent_b)
    );

    always @(posedge clk) begin
        p1_b <= {4'h0, addr_b} ^ 8'h5A;
        p2_b <= p1_b;
        p3_b <= p2_b;
    end
    always @(posedge clk) begin
        if (txs_b) begin
            ub_b <= 1'b1;
            uc_b <= 5;
        end else if (ub_b) begin
            if (uc_b == 1) ub_b <= 1'b0;
            uc_b <= uc_b - 1;
        end
    end
    assign busy_b = ub_b;

    // ---------------- instance C ----------------
    logic       start_c = 1'b0;
    logic [3:0] addr_c;
    logic       we_c;
    logic [7:0] rd_c = 8'h00;
    logic       busy_c;
    logic       txs_c;
    logic [7:0] txd_c;
    logic       done_c;
    logic [4:0] sent_c;
    logic       ub_c = 1'b0;
    int         uc_c = 0;

    memory_to_uart_sender #(.ADDR_WIDTH(4), .BYTE_COUNT(1), .RAM_READ_LATENCY(1)) u_c (
        .MAIN_CLOCK(clk), .RESET(rst), .START_TRANSMISSION(start_c),
        .RAM_ADDRESS(addr_c), .UART_WRITE_EN(we_c), .RAM_DATA(rd_c),
        .TX_BUSY(busy_c), .TX_START(txs_c), .TX_DATA(txd_c),
        .TRANSMISSION_DONE(done_c), .BYTES_SENT(sent_c)
    );

    always @(posedge clk) rd_c <= mem_a[addr_c[1:0]];
    always @(posedge clk) begin
        if (txs_c) begin
            ub_c <= 1'b1;
            uc_c <= 4;
        end else if (ub_c) begin
            if (uc_c == 1) ub_c <= 1'b0;
            uc_c <= uc_c - 1;
        end
    end
    assign busy_c = ub_c;

    // ---------------- pulse monitors (sampled on the falling edge) ----------------
    int         cnt_a = 0, cnt_b = 0, cnt_c = 0;
    int         viol_a = 0, viol_b = 0;
    logic [7:0] prev_a = 8'h00, prev_b = 8'h00;
    logic [7:0] dat_a [0:255];
    logic [7:0] dat_b [0:255];
    logic [7:0] dat_c [0:255];
    int         pc_a  [0:255];
    int         pc_b  [0:255];

    always @(negedge clk) begin
        if (txs_a) begin
            dat_a[cnt_a[7:0]] <= txd_a;
            pc_a[cnt_a[7:0]]  <= cyc;
            cnt_a             <= cnt_a + 1;
        end
        if (busy_a && (txd_a !== prev_a)) viol_a <= viol_a + 1;
        prev_a <= txd_a;
        if (txs_b) begin
            dat_b[cnt_b[7:0]] <= txd_b;
            pc_b[cnt_b[7:0]]  <= cyc;
            cnt_b             <= cnt_b + 1;
        end
        if (busy_b && (txd_b !== prev_b)) viol_b <= viol_b + 1;
        prev_b <= txd_b;
        if (txs_c) begin
            dat_c[cnt_c[7:0]] <= txd_c;
            cnt_c             <= cnt_c + 1;
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (addr_a !== 4'h0)  begin errors++; $display("FAIL reset_addr got %h exp 0", addr_a); end
        checks++; if (txs_a !== 1'b0)   begin errors++; $display("FAIL reset_txstart got %b exp 0", txs_a); end
        checks++; if (txd_a !== 8'h00)  begin errors++; $display("FAIL reset_txdata got %h exp 00", txd_a); end
        checks++; if (done_a !== 1'b0)  begin errors++; $display("FAIL reset_done got %b exp 0", done_a); end
        checks++; if (sent_a !== 5'd0)  begin errors++; $display("FAIL reset_sent got %0d exp 0", sent_a); end
        checks++; if (we_a !== 1'b0)    begin errors++; $display("FAIL reset_we got %b exp 0", we_a); end
        checks++; if ({we_b, we_c, txs_b, txs_c} !== 4'b0000) begin
            errors++; $display("FAIL reset_bc got %b exp 0000", {we_b, we_c, txs_b, txs_c});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_done_a(input int budget);
        for (int i = 0; i < budget && done_a !== 1'b1; i++) @(negedge clk);
        checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL done_a_timeout got %b exp 1", done_a); end
    endtask

    task automatic stop_a();
        start_a = 1'b0;
        repeat (25) @(negedge clk);
    endtask

    task automatic test_basic();
        int base, n0, v0, donecyc;
        base = cnt_a; v0 = viol_a; n0 = cyc;
        start_a = 1'b1;
        wait_done_a(400);
        donecyc = cyc;
        @(negedge clk);
        checks++; if (cnt_a !== base + 4) begin errors++; $display("FAIL basic_pulses got %0d exp 4", cnt_a - base); end
        checks++; if (dat_a[base] !== 8'hA5)   begin errors++; $display("FAIL basic_byte0 got %h exp A5", dat_a[base]); end
        checks++; if (dat_a[base+1] !== 8'h3C) begin errors++; $display("FAIL basic_byte1 got %h exp 3C", dat_a[base+1]); end
        checks++; if (dat_a[base+2] !== 8'hFF) begin errors++; $display("FAIL basic_byte2 got %h exp FF", dat_a[base+2]); end
        checks++; if (dat_a[base+3] !== 8'h00) begin errors++; $display("FAIL basic_byte3 got %h exp 00", dat_a[base+3]); end
        checks++; if (pc_a[base] !== n0 + 3) begin errors++; $display("FAIL basic_latency got %0d exp %0d", pc_a[base] - n0, 3); end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (pc_a[base+i] - pc_a[base+i-1] !== 14) begin
                errors++; $display("FAIL basic_spacing%0d got %0d exp 14", i, pc_a[base+i] - pc_a[base+i-1]);
            end
        end
        checks++; if (donecyc !== pc_a[base+3] + 12) begin errors++; $display("FAIL basic_done_time got %0d exp %0d", donecyc, pc_a[base+3] + 12); end
        checks++; if (sent_a !== 5'd4) begin errors++; $display("FAIL basic_sent got %0d exp 4", sent_a); end
        checks++; if (addr_a !== 4'h3) begin errors++; $display("FAIL basic_addr got %h exp 3", addr_a); end
        checks++; if (viol_a !== v0)   begin errors++; $display("FAIL basic_txdata_stable got %0d changes exp 0", viol_a - v0); end
        start_a = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({done_a, addr_a, sent_a} !== 10'd0) begin
            errors++; $display("FAIL basic_idle got done=%b addr=%h sent=%0d exp 0", done_a, addr_a, sent_a);
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_busy_hold();
        int base, f;
        base = cnt_a;
        force_busy = 1'b1;
        start_a = 1'b1;
        repeat (50) @(negedge clk);
        checks++; if (cnt_a !== base) begin errors++; $display("FAIL busy_hold_pulses got %0d exp 0", cnt_a - base); end
        f = cyc;
        force_busy = 1'b0;
        for (int i = 0; i < 20 && cnt_a == base; i++) @(negedge clk);
        checks++; if (cnt_a === base) begin errors++; $display("FAIL busy_hold_timeout got 0 pulses exp 1"); end
        checks++; if (pc_a[base] !== f + 1) begin errors++; $display("FAIL busy_hold_delay got %0d exp %0d", pc_a[base], f + 1); end
        checks++; if (dat_a[base] !== 8'hA5) begin errors++; $display("FAIL busy_hold_data got %h exp A5", dat_a[base]); end
        wait_done_a(400);
        stop_a();
    endtask

    task automatic test_abort();
        int base;
        base = cnt_a;
        start_a = 1'b1;
        for (int i = 0; i < 200 && cnt_a < base + 2; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        start_a = 1'b0;
        repeat (30) @(negedge clk);
        checks++; if (cnt_a !== base + 2) begin errors++; $display("FAIL abort_pulses got %0d exp 2", cnt_a - base); end
        checks++; if (addr_a !== 4'h0) begin errors++; $display("FAIL abort_addr got %h exp 0", addr_a); end
        checks++; if (sent_a !== 5'd0) begin errors++; $display("FAIL abort_sent got %0d exp 0", sent_a); end
        start_a = 1'b1;
        for (int i = 0; i < 100 && cnt_a < base + 3; i++) @(negedge clk);
        @(negedge clk);
        checks++; if (dat_a[base+2] !== 8'hA5) begin errors++; $display("FAIL abort_restart_data got %h exp A5", dat_a[base+2]); end
        wait_done_a(400);
        checks++; if (sent_a !== 5'd4) begin errors++; $display("FAIL abort_resend_sent got %0d exp 4", sent_a); end
        stop_a();
    endtask

    task automatic test_reset_mid();
        int base;
        base = cnt_a;
        start_a = 1'b1;
        for (int i = 0; i < 200 && cnt_a < base + 2; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (addr_a !== 4'h0) begin errors++; $display("FAIL rstmid_addr got %h exp 0", addr_a); end
        checks++; if (sent_a !== 5'd0) begin errors++; $display("FAIL rstmid_sent got %0d exp 0", sent_a); end
        checks++; if (txd_a !== 8'h00) begin errors++; $display("FAIL rstmid_txdata got %h exp 00", txd_a); end
        checks++; if ({txs_a, done_a} !== 2'b00) begin errors++; $display("FAIL rstmid_flags got %b exp 00", {txs_a, done_a}); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 100 && cnt_a < base + 3; i++) @(negedge clk);
        @(negedge clk);
        checks++; if (dat_a[base+2] !== 8'hA5) begin errors++; $display("FAIL rstmid_restart_data got %h exp A5", dat_a[base+2]); end
        wait_done_a(400);
        checks++; if (cnt_a !== base + 6) begin errors++; $display("FAIL rstmid_pulses got %0d exp 6", cnt_a - base); end
        checks++; if (sent_a !== 5'd4) begin errors++; $display("FAIL rstmid_sent_final got %0d exp 4", sent_a); end
        stop_a();
    endtask

    task automatic test_single_byte();
        start_c = 1'b1;
        for (int i = 0; i < 100 && done_c !== 1'b1; i++) @(negedge clk);
        checks++; if (done_c !== 1'b1) begin errors++; $display("FAIL single_done got %b exp 1", done_c); end
        repeat (20) @(negedge clk);
        checks++; if (cnt_c !== 1) begin errors++; $display("FAIL single_pulses got %0d exp 1", cnt_c); end
        checks++; if (dat_c[0] !== 8'hA5) begin errors++; $display("FAIL single_data got %h exp A5", dat_c[0]); end
        checks++; if (sent_c !== 5'd1) begin errors++; $display("FAIL single_sent got %0d exp 1", sent_c); end
        checks++; if (addr_c !== 4'h0) begin errors++; $display("FAIL single_addr got %h exp 0", addr_c); end
        start_c = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_full_space_latency3();
        int n0;
        logic [7:0] exp_d;
        n0 = cyc;
        start_b = 1'b1;
        for (int i = 0; i < 800 && done_b !== 1'b1; i++) @(negedge clk);
        checks++; if (done_b !== 1'b1) begin errors++; $display("FAIL lat3_done got %b exp 1", done_b); end
        @(negedge clk);
        checks++; if (cnt_b !== 16) begin errors++; $display("FAIL lat3_pulses got %0d exp 16", cnt_b); end
        checks++; if (pc_b[0] !== n0 + 5) begin errors++; $display("FAIL lat3_latency got %0d exp 5", pc_b[0] - n0); end
        for (int i = 0; i < 16; i++) begin
            exp_d = 8'(i) ^ 8'h5A;
            checks++;
            if (dat_b[i] !== exp_d) begin errors++; $display("FAIL lat3_byte%0d got %h exp %h", i, dat_b[i], exp_d); end
            if (i > 0) begin
                checks++;
                if (pc_b[i] - pc_b[i-1] !== 11) begin
                    errors++; $display("FAIL lat3_spacing%0d got %0d exp 11", i, pc_b[i] - pc_b[i-1]);
                end
            end
        end
        checks++; if (sent_b !== 5'd16) begin errors++; $display("FAIL lat3_sent got %0d exp 16", sent_b); end
        checks++; if (addr_b !== 4'hF)  begin errors++; $display("FAIL lat3_addr got %h exp F", addr_b); end
        checks++; if (viol_b !== 0)     begin errors++; $display("FAIL lat3_txdata_stable got %0d changes exp 0", viol_b); end
        start_b = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_busy_hold();
        test_abort();
        test_reset_mid();
        test_single_byte();
        test_full_space_latency3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
